// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding, digit geometry and the add-3 threshold, plus a
// constant function used to reject BIN_W/DIGITS pairs that cannot hold
// the full binary range.
package bcd_pkg;

    // Converter control states.
    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    // Width of one BCD digit.
    localparam int DIGIT_W = 4;

    // Digits at or above this value get +3 before each shift so that the
    // following doubling carries correctly into the next decade.
    localparam int ADD3_THRESH = 5;

    // True when DIGITS decimal digits can represent every value of a
    // BIN_W-bit unsigned number, i.e. 10**digits > 2**bin_w - 1.
    function automatic bit bcd_fits(input int bin_w, input int digits);
        longint unsigned max_val;
        longint unsigned p;
        max_val = (64'd1 << bin_w) - 64'd1;
        p       = 64'd1;
        for (int i = 0; i < digits; i++) begin
            // Stop early once the range is covered so p cannot overflow.
            if (p > max_val) begin
                return 1'b1;
            end
            p = p * 64'd10;
        end
        return (p > max_val);
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Per-digit double-dabble adjust: a BCD digit of 5 or more gets 3 added
// so that the following left shift produces a correct decimal carry.
// Purely combinational; the top instantiates one per digit.
module bcd_add3
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_in,
    output logic [DIGIT_W-1:0] digit_out
);

    // Conditional +3 on digits at or above the threshold.
    always_comb begin
        digit_out = (digit_in >= DIGIT_W'(ADD3_THRESH)) ? (digit_in + DIGIT_W'(3))
                                                         : digit_in;
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Iterative binary-to-BCD converter (shift-add-3 / double dabble).
//
// A start in IDLE latches bin_in and performs the first shift on the
// same edge; BIN_W-1 further shifts follow in SHIFT, then one DONE cycle
// registers the result into bcd_out and pulses done. Results hold until
// the next conversion completes, so downstream seven-segment decoders
// never see an intermediate value.
//
// Optional feature macro: BCD_LEADING_BLANK_EN
//   defined   - blank[i] (i >= 1) flags digit i as a leading zero;
//               blank[0] is always 0 so a zero result still shows "0".
//   undefined - blank is tied to 0 and no blanking logic exists.
module bin_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 4
) (
    input  logic                  CLOCK_50,
    input  logic                  RST,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     blank
);

    localparam int ACC_W = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    // The accept edge already performs shift number one, so SHIFT only
    // has BIN_W-1 shifts left; the counter reaching 1 marks the last.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BIN_W - 1);

    // Refuse to build a converter whose digits cannot hold 2**BIN_W - 1.
    if (!bcd_fits(BIN_W, DIGITS)) begin : g_bad_params
        $error("bin_to_bcd_seq: DIGITS too small for BIN_W");
    end

    state_t               state_q;
    state_t               state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [ACC_W-1:0]     acc_q;
    logic [ACC_W-1:0]     acc_adj;
    logic [BIN_W-1:0]     sr_q;
    logic                 load;
    logic                 shift_en;
    logic                 finish;

    // One add-3 cell per accumulator digit.
    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .digit_in  (acc_q[g*DIGIT_W +: DIGIT_W]),
            .digit_out (acc_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // FSM state register.
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state and control decode.
    // NOTE: every output of this block is given a default first so no path
    // leaves a variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        shift_en = 1'b0;
        finish   = 1'b0;
        busy     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    // A 1-bit input is fully shifted on the accept edge.
                    state_d = (BIN_W == 1) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                busy     = 1'b1;
                shift_en = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                finish  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Shift datapath: accept folds the load and the first shift together
    // (the accumulator is empty then, so no adjust is needed); each SHIFT
    // cycle adjusts all digits and moves the {acc, sr} pair left by one.
    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            cnt_q <= '0;
            acc_q <= '0;
            sr_q  <= '0;
        end else if (load) begin
            acc_q <= ACC_W'(bin_in[BIN_W-1]);
            sr_q  <= bin_in << 1;
            cnt_q <= CNT_LOAD;
        end else if (shift_en) begin
            // The dropped top bit is always zero for a legal BIN_W/DIGITS pair.
            acc_q <= ACC_W'({acc_adj, sr_q[BIN_W-1]});
            sr_q  <= sr_q << 1;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    // Result register and done pulse; bcd_out only changes in DONE.
    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            bcd_out <= '0;
            done    <= 1'b0;
        end else begin
            done <= finish;
            if (finish) begin
                bcd_out <= acc_q;
            end
        end
    end

`ifdef BCD_LEADING_BLANK_EN
    logic [DIGITS-1:0] blank_d;

    // Leading-zero detect, scanning from the most significant digit down.
    always_comb begin
        logic upper_zero;
        blank_d    = '0;
        upper_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            upper_zero = upper_zero && (acc_q[i*DIGIT_W +: DIGIT_W] == '0);
            blank_d[i] = upper_zero;
        end
    end

    // Blank flags update together with bcd_out; reset shows a single "0".
    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            blank <= ~DIGITS'(1);
        end else if (finish) begin
            blank <= blank_d;
        end
    end
`else
    assign blank = '0;
`endif

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq (default BIN_W=10, DIGITS=4).
// A cycle-level behavioural model predicts busy/done/bcd_out/blank from
// decimal arithmetic; a compare process checks every cycle, and directed
// scenarios pin the model with hand-computed literals.
module tb_bin_to_bcd_seq;

    localparam int BIN_W  = 10;
    localparam int DIGITS = 4;

    logic                 clk;
    logic                 RST;
    logic                 start;
    logic [BIN_W-1:0]     bin_in;
    logic                 busy;
    logic                 done;
    logic [4*DIGITS-1:0]  bcd_out;
    logic [DIGITS-1:0]    blank;

    int n_checks = 0;
    int n_pass   = 0;
    bit check_en = 1'b0;

    bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
        .CLOCK_50 (clk),
        .RST      (RST),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .blank    (blank)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected blank for a given "feature on" pattern in this build.
    function automatic logic [DIGITS-1:0] blank_lit(input logic [DIGITS-1:0] lit);
`ifdef BCD_LEADING_BLANK_EN
        return lit;
`else
        return '0;
`endif
    endfunction

    // Decimal digits of v, units in the lowest nibble.
    function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
        logic [4*DIGITS-1:0] r = '0;
        int p = 1;
        for (int d = 0; d < DIGITS; d++) begin
            r[d*4 +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Digit i (i >= 1) is a leading zero exactly when v < 10**i.
    function automatic logic [DIGITS-1:0] blank_of(input int v);
        logic [DIGITS-1:0] b = '0;
        int p = 10;
        for (int i = 1; i < DIGITS; i++) begin
            b[i] = (v < p);
            p = p * 10;
        end
        return blank_lit(b);
    endfunction

    // Behavioural model: a conversion accepted at edge k finishes BIN_W
    // edges later; the edge after that is the first that may accept again.
    int                   m_rem;
    logic [BIN_W-1:0]     m_val;
    logic                 m_busy;
    logic                 m_done;
    logic [4*DIGITS-1:0]  m_bcd;
    logic [DIGITS-1:0]    m_blank;

    always @(posedge clk) begin
        int rem;
        if (RST) begin
            m_rem   <= 0;
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_bcd   <= '0;
            m_blank <= blank_lit(~DIGITS'(1));
        end else begin
            rem = m_rem;
            m_done <= 1'b0;
            if (rem > 0) begin
                rem = rem - 1;
                if (rem == 0) begin
                    m_done  <= 1'b1;
                    m_bcd   <= to_bcd(int'(m_val));
                    m_blank <= blank_of(int'(m_val));
                end
            end else if (start) begin
                m_val <= bin_in;
                rem   = BIN_W;
            end
            m_rem  <= rem;
            m_busy <= (rem > 0);
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (check_en) begin
            logic digits_ok;
            digits_ok = 1'b1;
            for (int d = 0; d < DIGITS; d++) begin
                if (bcd_out[d*4 +: 4] > 4'd9) digits_ok = 1'b0;
            end
            check("busy", busy, m_busy);
            check("done", done, m_done);
            check("bcd_out", bcd_out, m_bcd);
            check("blank", blank, m_blank);
            check("digit_range", digits_ok, 1'b1);
        end
    end

    // Single conversion with literal expectations on latency and result.
    task automatic run_conv(input int val, input logic [15:0] exp_bcd,
                            input logic [3:0] exp_blank_on, input string tag);
        int n;
        bit seen;
        @(negedge clk);
        start  = 1'b1;
        bin_in = 10'(val);
        @(negedge clk);
        start  = 1'b0;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (done) seen = 1'b1;
        end
        check({tag, "_latency"}, n, 10);
        check({tag, "_bcd"}, bcd_out, exp_bcd);
        check({tag, "_blank"}, blank, blank_lit(exp_blank_on));
    endtask

    initial begin
        int n;
        int n_done;
        bit seen;

        RST    = 1'b1;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) @(negedge clk);
        check_en = 1'b1;

        // Reset values.
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_bcd", bcd_out, 16'h0000);
        check("rst_blank", blank, blank_lit(4'b1110));
        RST = 1'b0;

        // Directed conversions.
        run_conv(0,    16'h0000, 4'b1110, "zero");
        run_conv(1023, 16'h1023, 4'b0000, "max");
        run_conv(509,  16'h0509, 4'b1000, "v509");
        run_conv(7,    16'h0007, 4'b1110, "v7");

        // Starts during a conversion and bin_in changes are ignored.
        @(negedge clk);
        start  = 1'b1;
        bin_in = 10'd300;
        @(negedge clk);
        start  = 1'b0;
        bin_in = 10'd999;
        n_done = 0;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (done) n_done++;
            start = (c == 3 || c == 6);
        end
        start = 1'b0;
        check("ignore_start_dones", n_done, 1);
        check("ignore_start_bcd", bcd_out, 16'h0300);

        // Reset mid-conversion aborts without a done pulse.
        @(negedge clk);
        start  = 1'b1;
        bin_in = 10'd1000;
        @(negedge clk);
        start  = 1'b0;
        repeat (4) @(negedge clk);
        RST = 1'b1;
        @(negedge clk);
        RST = 1'b0;
        n_done = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_dones", n_done, 0);
        check("abort_bcd", bcd_out, 16'h0000);
        check("abort_busy", busy, 1'b0);
        check("abort_blank", blank, blank_lit(4'b1110));

        // Reset and start together: reset wins.
        @(negedge clk);
        RST    = 1'b1;
        start  = 1'b1;
        bin_in = 10'd5;
        @(negedge clk);
        RST   = 1'b0;
        start = 1'b0;
        n_done = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("rst_start_dones", n_done, 0);
        check("rst_start_busy", busy, 1'b0);

        run_conv(42, 16'h0042, 4'b1100, "v42");

        // Back-to-back sweep with start held high: one result per 11 cycles.
        @(negedge clk);
        start  = 1'b1;
        bin_in = '0;
        for (int v = 0; v < 1024; v++) begin
            n    = 0;
            seen = 1'b0;
            while (!seen && n < 30) begin
                @(negedge clk);
                n++;
                if (done) seen = 1'b1;
            end
            check("sweep_period", n, 11);
            bin_in = 10'(v + 1);
            if (v == 1023) start = 1'b0;
        end

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            start  = ($urandom_range(0, 2) == 0);
            bin_in = 10'($urandom);
            RST    = ($urandom_range(0, 299) == 0);
        end
        RST   = 1'b0;
        start = 1'b0;
        repeat (15) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
